// File: rtl/tf_fetch_scheduler.sv
// Twiddle-factor fetch scheduler: walks stage/group ROM addresses, hides the 1-cycle
// ROM latency behind a 2-entry buffer and streams each factor as GROUP_LEN beats.
module tf_fetch_scheduler #(
  parameter int unsigned P_WIDTH    = 64,
  parameter int unsigned IDX_WIDTH  = 6,
  parameter int unsigned SC_WIDTH   = 3,
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned NUM_GROUPS = 4,
  parameter int unsigned GROUP_LEN  = 16,
  parameter int unsigned IDX_START  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  output logic                 o_rom_cen,
  output logic [IDX_WIDTH-1:0] o_rom_addr,
  input  logic [P_WIDTH-1:0]   i_rom_q,
  output logic                 o_tf_valid,
  input  logic                 i_tf_ready,
  output logic [P_WIDTH-1:0]   o_tf_data,
  output logic [SC_WIDTH-1:0]  o_tf_stage,
  output logic [IDX_WIDTH-1:0] o_tf_group,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int unsigned BEAT_W = (GROUP_LEN > 1) ? $clog2(GROUP_LEN) : 1;

  typedef struct packed {
    logic [P_WIDTH-1:0]   data;
    logic [SC_WIDTH-1:0]  stage;
    logic [IDX_WIDTH-1:0] group;
  } tf_entry_t;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t               r_state;
  logic [SC_WIDTH-1:0]  r_stage;
  logic [IDX_WIDTH-1:0] r_grp;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_inflight;
  logic [SC_WIDTH-1:0]  r_inf_stage;
  logic [IDX_WIDTH-1:0] r_inf_grp;
  logic [1:0]           r_count;
  tf_entry_t            r_head;
  tf_entry_t            r_tail;
  logic [BEAT_W-1:0]    r_beat;

  tf_entry_t            w_rom_entry;
  tf_entry_t            w_head;
  logic                 w_hd_valid;
  logic                 w_accept;
  logic                 w_pop;
  logic [1:0]           w_used;
  logic                 w_issue;
  logic                 w_last;
  logic [IDX_WIDTH-1:0] w_addr;

  // g * 4**s is a left shift by 2*s; truncation to IDX_WIDTH gives the modulo wrap
  assign w_addr      = IDX_WIDTH'(IDX_START) + (r_grp << {r_stage, 1'b0});
  assign w_rom_entry = {i_rom_q, r_inf_stage, r_inf_grp};
  assign w_hd_valid  = (r_count != 2'd0) || r_inflight;
  assign w_accept    = w_hd_valid && i_tf_ready;
  assign w_pop       = w_accept && (r_beat == BEAT_W'(GROUP_LEN - 1));
  // Credit counts the slot freed by this cycle's pop so GROUP_LEN=1 runs at full rate
  assign w_used      = r_count + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_issue     = (r_state == S_FETCH) && !i_abort && (w_used < 2'd2);
  assign w_last      = w_pop && ((r_count + {1'b0, r_inflight}) == 2'd1);

  // Head of the queue; an empty buffer forwards the in-flight ROM word directly
  always_comb begin
    w_head = '0;
    if (r_count != 2'd0) begin
      w_head = r_head;
    end else if (r_inflight) begin
      w_head = w_rom_entry;
    end
  end

  assign o_rom_cen  = !w_issue;
  assign o_rom_addr = w_issue ? w_addr : '0;
  assign o_tf_valid = w_hd_valid;
  assign o_tf_data  = w_head.data;
  assign o_tf_stage = w_head.stage;
  assign o_tf_group = w_head.group;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

  // Frame sequencing: stage-major, group-minor read order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_stage <= '0;
      r_grp   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_abort) begin
      r_state <= S_IDLE;
      r_stage <= '0;
      r_grp   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (i_start) begin
            r_state <= S_FETCH;
            r_busy  <= 1'b1;
            r_stage <= '0;
            r_grp   <= '0;
          end
        end
        S_FETCH: begin
          if (w_issue) begin
            if (r_grp == IDX_WIDTH'(NUM_GROUPS - 1)) begin
              r_grp <= '0;
              if (r_stage == SC_WIDTH'(NUM_STAGES - 1)) begin
                r_state <= S_DRAIN;
              end else begin
                r_stage <= r_stage + SC_WIDTH'(1);
              end
            end else begin
              r_grp <= r_grp + IDX_WIDTH'(1);
            end
          end
        end
        S_DRAIN: begin
          if (w_last) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read tracking, 2-entry buffer and per-entry beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight  <= 1'b0;
      r_inf_stage <= '0;
      r_inf_grp   <= '0;
      r_count     <= 2'd0;
      r_head      <= '0;
      r_tail      <= '0;
      r_beat      <= '0;
    end else if (i_abort) begin
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
      r_beat     <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inf_stage <= r_stage;
        r_inf_grp   <= r_grp;
      end
      if (w_pop) begin
        r_beat <= '0;
      end else if (w_accept) begin
        r_beat <= r_beat + BEAT_W'(1);
      end
      case (r_count)
        2'd0: begin
          if (r_inflight && !w_pop) begin
            r_head  <= w_rom_entry;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          if (w_pop) begin
            if (r_inflight) begin
              r_head <= w_rom_entry;
            end else begin
              r_count <= 2'd0;
            end
          end else if (r_inflight) begin
            r_tail  <= w_rom_entry;
            r_count <= 2'd2;
          end
        end
        default: begin
          if (w_pop) begin
            r_head  <= r_tail;
            r_count <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tf_fetch_scheduler.sv
// Bench for tf_fetch_scheduler: scoreboarded frames on a default instance plus a
// GROUP_LEN=1 instance for the full-rate case.
module tb_tf_fetch_scheduler;

  localparam int unsigned PW = 64;
  localparam int unsigned IW = 6;
  localparam int unsigned SW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          a_start = 1'b0, a_abort = 1'b0, a_ready = 1'b1;
  logic          a_cen, a_valid, a_busy, a_done;
  logic [IW-1:0] a_addr, a_group;
  logic [SW-1:0] a_stage;
  logic [PW-1:0] a_rom_q = '0, a_data;

  logic          b_start = 1'b0, b_abort = 1'b0, b_ready = 1'b1;
  logic          b_cen, b_valid, b_busy, b_done;
  logic [IW-1:0] b_addr, b_group;
  logic [SW-1:0] b_stage;
  logic [PW-1:0] b_rom_q = '0, b_data;

  tf_fetch_scheduler u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(a_start), .i_abort(a_abort),
    .o_rom_cen(a_cen), .o_rom_addr(a_addr), .i_rom_q(a_rom_q),
    .o_tf_valid(a_valid), .i_tf_ready(a_ready), .o_tf_data(a_data),
    .o_tf_stage(a_stage), .o_tf_group(a_group), .o_busy(a_busy), .o_done(a_done)
  );

  tf_fetch_scheduler #(.GROUP_LEN(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(b_start), .i_abort(b_abort),
    .o_rom_cen(b_cen), .o_rom_addr(b_addr), .i_rom_q(b_rom_q),
    .o_tf_valid(b_valid), .i_tf_ready(b_ready), .o_tf_data(b_data),
    .o_tf_stage(b_stage), .o_tf_group(b_group), .o_busy(b_busy), .o_done(b_done)
  );

  // Registered ROM models: word = address
  always @(posedge clk) if (!a_cen) a_rom_q <= PW'(a_addr);
  always @(posedge clk) if (!b_cen) b_rom_q <= PW'(b_addr);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_addr(input int s, input int g);
    return (1 + g * (4 ** s)) % 64;
  endfunction

  typedef struct {
    logic [63:0]   data;
    logic [SW-1:0] stage;
    logic [IW-1:0] group;
  } beat_t;

  beat_t         a_exp[$];
  logic [IW-1:0] a_rd_exp[$];
  int            a_reads = 0, a_beats = 0, a_dones = 0;

  task automatic push_frame();
    for (int s = 0; s < 4; s++) begin
      for (int g = 0; g < 4; g++) begin
        a_rd_exp.push_back(IW'(exp_addr(s, g)));
        repeat (16) a_exp.push_back('{64'(exp_addr(s, g)), SW'(s), IW'(g)});
      end
    end
  endtask

  // Monitor for instance A: read order, beat scoreboard, stall stability, done
  logic          a_held = 1'b0;
  logic [63:0]   h_data;
  logic [IW+SW-1:0] h_tag;
  beat_t         e;
  logic [IW-1:0] ea;
  always @(negedge clk) begin
    if (!rst_n) begin
      a_held = 1'b0;
    end else begin
      if (!a_cen) begin
        a_reads++;
        if (a_rd_exp.size() == 0) begin
          check("unexpected_read", 64'(a_addr), 64'hFFFF);
        end else begin
          ea = a_rd_exp.pop_front();
          check("rom_addr", 64'(a_addr), 64'(ea));
        end
      end
      if (a_held) begin
        check("hold_valid", 64'(a_valid), 64'd1);
        check("hold_data", a_data, h_data);
        check("hold_tag", 64'({a_stage, a_group}), 64'(h_tag));
      end
      if (a_valid && a_ready) begin
        a_beats++;
        if (a_exp.size() == 0) begin
          check("unexpected_beat", a_data, 64'hDEAD);
        end else begin
          e = a_exp.pop_front();
          check("beat_data", a_data, e.data);
          check("beat_tag", 64'({a_stage, a_group}), 64'({e.stage, e.group}));
        end
      end
      if (a_done) begin
        a_dones++;
        check("busy_at_done", 64'(a_busy), 64'd1);
      end
      a_held = a_valid && !a_ready;
      h_data = a_data;
      h_tag  = {a_stage, a_group};
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_cen"},   64'(a_cen),   64'd1);
    check({tag, "_addr"},  64'(a_addr),  64'd0);
    check({tag, "_valid"}, 64'(a_valid), 64'd0);
    check({tag, "_data"},  a_data,       64'd0);
    check({tag, "_stage"}, 64'(a_stage), 64'd0);
    check({tag, "_group"}, 64'(a_group), 64'd0);
    check({tag, "_busy"},  64'(a_busy),  64'd0);
    check({tag, "_done"},  64'(a_done),  64'd0);
  endtask

  // Loads the expected frame and pulses start; returns #1 into cycle 1
  task automatic start_a();
    push_frame();
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
  endtask

  // toggle=1 alternates tf_ready every cycle while waiting
  task automatic wait_done(input int budget, input bit toggle, input string name);
    int d0 = a_dones;
    int k  = 0;
    while (a_dones == d0 && k < budget) begin
      @(posedge clk); #1;
      if (toggle) a_ready = ~a_ready;
      k++;
    end
    a_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done_once"}, 64'(a_dones - d0), 64'd1);
    check({name, "_busy_low"}, 64'(a_busy), 64'd0);
    check({name, "_beats_left"}, 64'(a_exp.size()), 64'd0);
    check({name, "_reads_left"}, 64'(a_rd_exp.size()), 64'd0);
  endtask

  typedef struct {
    int hold;
    int exp_reads;
    bit exp_valid;
  } stall_vec_t;

  stall_vec_t sv[4];

  initial begin
    sv[0] = '{1, 1, 1'b1};
    sv[1] = '{2, 2, 1'b1};
    sv[2] = '{3, 2, 1'b1};
    sv[3] = '{50, 2, 1'b1};

    repeat (3) @(posedge clk);
    #1 check_reset("por");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Full frame, ready high, with start-to-output latency
    start_a();
    check("lat_cen_c1", 64'(a_cen), 64'd0);
    check("lat_busy_c1", 64'(a_busy), 64'd1);
    check("lat_valid_c1", 64'(a_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_valid_c2", 64'(a_valid), 64'd1);
    check("lat_data_c2", a_data, 64'd1);
    wait_done(400, 1'b0, "frame");

    // Ready toggling 1-0
    start_a();
    wait_done(800, 1'b1, "toggle");

    // Stall after start: reads limited by buffer credit
    for (int i = 0; i < 4; i++) begin
      int r0;
      r0 = a_reads;
      a_ready = 1'b0;
      start_a();
      repeat (sv[i].hold) @(posedge clk);
      #1;
      check("stall_reads", 64'(a_reads - r0), 64'(sv[i].exp_reads));
      check("stall_valid", 64'(a_valid), 64'(sv[i].exp_valid));
      if (sv[i].hold > 2) check("stall_cen_idle", 64'(a_cen), 64'd1);
      a_ready = 1'b1;
      wait_done(400, 1'b0, "stall");
    end

    // GROUP_LEN=1 instance: 16 beats back to back
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    @(negedge clk);
    check("g1_valid_c1", 64'(b_valid), 64'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("g1_valid", 64'(b_valid), 64'd1);
      check("g1_data", b_data, 64'(exp_addr(i / 4, i % 4)));
      check("g1_tag", 64'({b_stage, b_group}), 64'({SW'(i / 4), IW'(i % 4)}));
    end
    @(negedge clk);
    check("g1_valid_end", 64'(b_valid), 64'd0);
    check("g1_done", 64'(b_done), 64'd1);
    check("g1_busy_at_done", 64'(b_busy), 64'd1);

    // Abort at beat 37, then a clean restart
    begin
      int b0, d0, k;
      b0 = a_beats;
      k  = 0;
      start_a();
      while ((a_beats - b0) < 37 && k < 200) begin
        @(posedge clk); #1;
        k++;
      end
      check("abort_reach_37", 64'((a_beats - b0) >= 37), 64'd1);
      a_abort = 1'b1;
      @(posedge clk); #1 a_abort = 1'b0;
      a_exp.delete();
      a_rd_exp.delete();
      check("abort_valid", 64'(a_valid), 64'd0);
      check("abort_busy", 64'(a_busy), 64'd0);
      d0 = a_dones;
      repeat (20) @(posedge clk);
      #1;
      check("abort_no_done", 64'(a_dones - d0), 64'd0);
      check("abort_cen_idle", 64'(a_cen), 64'd1);
      start_a();
      check("restart_cen", 64'(a_cen), 64'd0);
      check("restart_addr", 64'(a_addr), 64'd1);
      wait_done(400, 1'b0, "restart");
    end

    // Start while busy is ignored; reset mid-drain returns to reset values
    begin
      int d0, k;
      start_a();
      repeat (20) @(posedge clk);
      #1 a_start = 1'b1;
      @(posedge clk); #1 a_start = 1'b0;
      check("busy_start_busy", 64'(a_busy), 64'd1);
      k = 0;
      while (a_rd_exp.size() != 0 && k < 400) begin
        @(posedge clk); #1;
        k++;
      end
      check("drain_reached", 64'(a_rd_exp.size()), 64'd0);
      repeat (5) @(posedge clk);
      #1;
      check("drain_valid", 64'(a_valid), 64'd1);
      d0 = a_dones;
      rst_n = 1'b0;
      #1 check_reset("mid_rst");
      a_exp.delete();
      a_rd_exp.delete();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("post_rst_no_done", 64'(a_dones - d0), 64'd0);
      check("post_rst_valid", 64'(a_valid), 64'd0);
      check("post_rst_busy", 64'(a_busy), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
